// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution datapath
// (multiplier and accumulator stages agree on bus widths through this package).
package conv_pkg;

  localparam int N_ELEM = 25;
  localparam int PROD_W = 16;
  localparam int ACC_W  = 24;
  localparam int PIX_W  = 8;
  localparam int IDX_W  = $clog2(N_ELEM);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_FINISH = 2'd2
  } conv_state_t;

endpackage

// File: rtl/saturador_pixel.sv
// Combinational clamp of a signed accumulator sum onto an unsigned pixel.
// Build option ACUM_ABS_EN: clamp |sum| instead of forcing negative sums to 0.
module saturador_pixel #(
  parameter int ACC_W = conv_pkg::ACC_W,
  parameter int PIX_W = conv_pkg::PIX_W
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic        [PIX_W-1:0] pixel
);

  localparam logic [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

  logic [ACC_W-1:0] mag;

`ifdef ACUM_ABS_EN
  assign mag = sum[ACC_W-1] ? ACC_W'(-sum) : ACC_W'(sum);
`else
  assign mag = sum[ACC_W-1] ? '0 : ACC_W'(sum);
`endif

  assign pixel = (mag > PIX_MAX) ? '1 : mag[PIX_W-1:0];

endmodule

// File: rtl/acumulador_convolucao.sv
// Serial accumulator for one 5x5 window of products: latch, sum one per cycle,
// then register raw sum and saturated pixel (ACUM_ABS_EN selects |sum| clamping).
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | waiting for start; latches products on start
// ST_ACCUM  | adds product[idx] each cycle, idx 0..N_ELEM-1
// ST_FINISH | registers sum_out/pixel_out, pulses done next
module acumulador_convolucao #(
  parameter int N_ELEM = conv_pkg::N_ELEM,
  parameter int PROD_W = conv_pkg::PROD_W,
  parameter int ACC_W  = conv_pkg::ACC_W,
  parameter int PIX_W  = conv_pkg::PIX_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic signed [N_ELEM*PROD_W-1:0] products_in,
  output logic signed [ACC_W-1:0]    sum_out,
  output logic        [PIX_W-1:0]    pixel_out,
  output logic                       done,
  output logic                       busy
);

  import conv_pkg::*;

  localparam int IDX_W_L = $clog2(N_ELEM);
  localparam logic [IDX_W_L-1:0] IDX_LAST = IDX_W_L'(N_ELEM - 1);

  conv_state_t state, state_nxt;

  logic [N_ELEM*PROD_W-1:0] prod_buf;
  logic signed [ACC_W-1:0]  acc;
  logic [IDX_W_L-1:0]       idx;
  logic signed [PROD_W-1:0] prod_sel;
  logic [PIX_W-1:0]         pixel_sat;
  logic                     load;
  logic                     step;
  logic                     finish;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        busy = 1'b1;
        step = 1'b1;
        if (idx == IDX_LAST) state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        busy      = 1'b1;
        finish    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign prod_sel = prod_buf[idx*PROD_W +: PROD_W];

  // Accumulator is wide enough for the worst-case window; no wrap handling needed.
  always_ff @(posedge clock) begin
    if (reset) begin
      prod_buf  <= '0;
      acc       <= '0;
      idx       <= '0;
      sum_out   <= '0;
      pixel_out <= '0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        prod_buf <= products_in;
        acc      <= '0;
        idx      <= '0;
      end
      if (step) begin
        acc <= acc + ACC_W'(prod_sel);
        idx <= idx + IDX_W_L'(1);
      end
      if (finish) begin
        sum_out   <= acc;
        pixel_out <= pixel_sat;
      end
    end
  end

  saturador_pixel #(
    .ACC_W (ACC_W),
    .PIX_W (PIX_W)
  ) u_saturador_pixel (
    .sum   (acc),
    .pixel (pixel_sat)
  );

endmodule

// File: tb/tb_acumulador_convolucao.sv
// Scoreboard bench for acumulador_convolucao: expected sum/pixel/latency are
// queued at each accepted start and compared when done pulses.
module tb_acumulador_convolucao;

  localparam int NE  = 25;
  localparam int PW  = 16;
  localparam int AW  = 24;
  localparam int XW  = 8;
  localparam int TOT = NE * PW;

  logic                 clock;
  logic                 reset;
  logic                 start;
  logic signed [TOT-1:0] products_in;
  logic signed [AW-1:0] sum_out;
  logic        [XW-1:0] pixel_out;
  logic                 done;
  logic                 busy;

  typedef struct {
    longint sum;
    longint pix;
    longint cyc;
  } exp_t;

  exp_t   q[$];
  int     n_cmp  = 0;
  int     n_bad  = 0;
  int     n_done = 0;
  longint cyc    = 0;

  acumulador_convolucao dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .products_in (products_in),
    .sum_out     (sum_out),
    .pixel_out   (pixel_out),
    .done        (done),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint exp_pix(input longint s);
    longint v;
    v = s;
`ifdef ACUM_ABS_EN
    if (v < 0) v = -v;
`endif
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic longint sum_of(input logic [TOT-1:0] p);
    longint s;
    logic signed [PW-1:0] e;
    s = 0;
    for (int j = 0; j < NE; j++) begin
      e = p[j*PW +: PW];
      s += longint'(e);
    end
    return s;
  endfunction

  function automatic logic [TOT-1:0] all_of(input int v);
    logic [TOT-1:0] p;
    for (int j = 0; j < NE; j++) p[j*PW +: PW] = PW'(v);
    return p;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("sum_out", longint'(sum_out), e.sum);
        chk("pixel_out", longint'(pixel_out), e.pix);
        chk("latency", cyc, e.cyc);
        chk("busy_in_done", longint'(busy), 0);
      end
      n_done++;
    end
  end

  // Call at a negedge: start is held across exactly one rising edge.
  task automatic pulse(input logic [TOT-1:0] p, input bit clobber);
    longint s;
    s = sum_of(p);
    start       = 1'b1;
    products_in = p;
    @(posedge clock);
    #1;
    q.push_back('{sum: s, pix: exp_pix(s), cyc: cyc + 26});
    if (clobber) products_in = '0;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_until(input int target, input string tag);
    for (int i = 0; i < 80 && n_done < target; i++) begin
      @(negedge clock);
      #1;
    end
    if (n_done < target) chk(tag, n_done, target);
  endtask

  task automatic window(input logic [TOT-1:0] p, input bit clobber, input string tag);
    int base;
    base = n_done;
    @(negedge clock);
    pulse(p, clobber);
    wait_until(base + 1, tag);
  endtask

  initial begin
    logic [TOT-1:0] p;
    int base;

    reset       = 1'b1;
    start       = 1'b0;
    products_in = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_sum", longint'(sum_out), 0);
    chk("rst_pixel", longint'(pixel_out), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_busy", longint'(busy), 0);
    reset = 1'b0;

    window(all_of(1), 0, "to_ones");
    @(negedge clock);
    chk("busy_after_ones", longint'(busy), 0);
    chk("sum_ones_const", longint'(sum_out), 25);

    p = '0; p[PW-1:0] = 16'd300;
    window(p, 0, "to_single300");
    chk("pix_single300_const", longint'(pixel_out), 255);

    window(all_of(-100), 0, "to_neg100");
    chk("sum_neg100_const", longint'(sum_out), -2500);

    for (int j = 0; j < NE; j++) p[j*PW +: PW] = PW'(j);
    window(p, 1, "to_ramp_clobber");
    chk("sum_ramp_const", longint'(sum_out), 300);

    window(all_of(32385), 0, "to_maxpos");
    chk("sum_maxpos_const", longint'(sum_out), 809625);
    window(all_of(-32640), 0, "to_maxneg");
    chk("sum_maxneg_const", longint'(sum_out), -816000);

    // Abort mid-window: outputs must clear and no done may follow.
    @(negedge clock);
    pulse(all_of(3), 0);
    repeat (9) @(negedge clock);
    chk("busy_mid_accum", longint'(busy), 1);
    reset = 1'b1;
    q.delete();
    @(negedge clock);
    reset = 1'b0;
    chk("abort_sum", longint'(sum_out), 0);
    chk("abort_pixel", longint'(pixel_out), 0);
    chk("abort_done", longint'(done), 0);
    chk("abort_busy", longint'(busy), 0);
    base = n_done;
    repeat (35) @(negedge clock);
    chk("abort_no_done", n_done, base);
    window(all_of(2), 0, "to_after_abort");

    // start during ACCUM is dropped.
    base = n_done;
    @(negedge clock);
    pulse(all_of(7), 0);
    repeat (4) @(negedge clock);
    start = 1'b1;
    products_in = all_of(9);
    @(negedge clock);
    start = 1'b0;
    wait_until(base + 1, "to_ignore");
    repeat (35) @(negedge clock);
    chk("ignore_one_done", n_done, base + 1);

    // Back-to-back: new start accepted in the done cycle.
    base = n_done;
    @(negedge clock);
    pulse(all_of(4), 0);
    for (int i = 0; i < 40 && !done; i++) @(negedge clock);
    chk("b2b_first_done", longint'(done), 1);
    pulse(all_of(-5), 0);
    wait_until(base + 2, "to_b2b");
    repeat (3) @(negedge clock);
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1);
  end

endmodule
